// File: rtl/flex_stp_pkg.sv
// Shared definitions for the serial-to-parallel deframer: shift direction
// encoding and the bit-counter width helper.
package flex_stp_pkg;

  // Shift direction selected by the SHIFT_MSB parameter.
  typedef enum logic {
    STP_TO_LSB = 1'b0,
    STP_TO_MSB = 1'b1
  } stp_dir_e;

  // Width needed to hold values 0..n (bit_count only reaches n-1, but this
  // keeps the width safe for every n >= 2).
  function automatic int stp_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/stp_bit_counter.sv
// Bit counter for the deframer: counts accepted bits of the current word and
// flags the completing bit with a combinational wrap pulse.
module stp_bit_counter
  import flex_stp_pkg::*;
#(
  parameter int NUM_BITS = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             enable,
  output logic [stp_cnt_w(NUM_BITS)-1:0]   count,
  output logic                             wrap
);

  localparam int CW = stp_cnt_w(NUM_BITS);
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Wrap fires on the bit that completes a word, independent of clear;
  // the top gates it when clear discards the shift.
  assign wrap  = enable && (count_q == LAST);
  assign count = count_q;

  // Next count: clear wins, then wrap to zero, then increment.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {CW{1'b0}};
    end else if (enable) begin
      if (count_q == LAST) begin
        count_d = {CW{1'b0}};
      end else begin
        count_d = count_q + CW'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/flex_stp_deframer.sv
// Serial-to-parallel receiver with word framing: shifts bits in, captures each
// completed word into a holding register offered on valid/ready, and flags a
// sticky overrun when a completed word has to be dropped.
module flex_stp_deframer
  import flex_stp_pkg::*;
#(
  parameter int   NUM_BITS   = 8,
  parameter bit   SHIFT_MSB  = 1'b1,
  parameter logic RESET_FILL = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           shift_enable,
  input  logic                           serial_in,
  input  logic                           clear,
  output logic [NUM_BITS-1:0]            parallel_out,
  output logic [stp_cnt_w(NUM_BITS)-1:0] bit_count,
  output logic [NUM_BITS-1:0]            word_data,
  output logic                           word_valid,
  input  logic                           word_ready,
  output logic                           overrun
);

  localparam stp_dir_e DIR = stp_dir_e'(SHIFT_MSB);
  localparam logic [NUM_BITS-1:0] FILL = {NUM_BITS{RESET_FILL}};

  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [NUM_BITS-1:0] word_q, word_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;
  logic [NUM_BITS-1:0] shifted_s;
  logic                wrap_s;
  logic                complete_s;
  logic                xfer_s;

  stp_bit_counter #(
    .NUM_BITS (NUM_BITS)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .enable (shift_enable),
    .count  (bit_count),
    .wrap   (wrap_s)
  );

  // A clear in the same cycle discards the shift, so no word completes.
  assign complete_s = wrap_s && !clear;
  assign xfer_s     = valid_q && word_ready;

  // Post-shift register value; also the candidate word on completion.
  always_comb begin
    shifted_s = shift_q;
    if (DIR == STP_TO_MSB) begin
      shifted_s = {shift_q[NUM_BITS-2:0], serial_in};
    end else begin
      shifted_s = {serial_in, shift_q[NUM_BITS-1:1]};
    end
  end

  // Next state for shift register, holding register, handshake and overrun.
  always_comb begin
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (clear) begin
      shift_d = FILL;
      ovr_d   = 1'b0;
    end else if (shift_enable) begin
      shift_d = shifted_s;
    end else begin
      shift_d = shift_q;
    end

    if (complete_s) begin
      if (!valid_q || word_ready) begin
        word_d  = shifted_s;
        valid_d = 1'b1;
      end else begin
        // Consumer still holds the previous word: drop the new one.
        ovr_d = 1'b1;
      end
    end else if (xfer_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= FILL;
      word_q  <= {NUM_BITS{1'b0}};
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign parallel_out = shift_q;
  assign word_data    = word_q;
  assign word_valid   = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_flex_stp_deframer.sv
// Self-checking bench: two deframers (SHIFT_MSB=1 and SHIFT_MSB=0) share one
// input stream and are compared every cycle against a bit-history model.
module tb_flex_stp_deframer;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       shift_enable = 1'b0;
  logic       serial_in = 1'b0;
  logic       clear = 1'b0;
  logic       word_ready = 1'b0;

  logic [N-1:0] pout_m, pout_l, word_m, word_l;
  logic [3:0]   cnt_m, cnt_l;
  logic         wv_m, wv_l, ovr_m, ovr_l;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state: every bit seen since the last reset/clear (newest at back),
  // preceded by N fill bits; words are views of its last N entries.
  bit       hist[$];
  int       m_cnt;
  logic [N-1:0] m_word_m, m_word_l;
  bit       m_valid, m_ovr;

  flex_stp_deframer #(.NUM_BITS(N), .SHIFT_MSB(1'b1), .RESET_FILL(1'b1)) dut_m (
    .clk(clk), .rst(rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .clear(clear), .parallel_out(pout_m), .bit_count(cnt_m), .word_data(word_m),
    .word_valid(wv_m), .word_ready(word_ready), .overrun(ovr_m));

  flex_stp_deframer #(.NUM_BITS(N), .SHIFT_MSB(1'b0), .RESET_FILL(1'b1)) dut_l (
    .clk(clk), .rst(rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .clear(clear), .parallel_out(pout_l), .bit_count(cnt_l), .word_data(word_l),
    .word_valid(wv_l), .word_ready(word_ready), .overrun(ovr_l));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // k-th newest bit lands in bit k (toward MSB) or bit N-1-k (toward LSB).
  function automatic logic [N-1:0] view(input bit to_msb);
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) begin
      if (to_msb) v[k] = hist[hist.size()-1-k];
      else        v[N-1-k] = hist[hist.size()-1-k];
    end
    return v;
  endfunction

  task automatic fill_hist();
    hist.delete();
    for (int k = 0; k < N; k++) hist.push_back(1'b1);
  endtask

  // Advance the model by one clock edge from the current inputs.
  task automatic model_step();
    bit done;
    bit xfer;
    done = 1'b0;
    xfer = m_valid && word_ready;
    if (rst) begin
      fill_hist();
      m_cnt = 0; m_word_m = '0; m_word_l = '0; m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      if (clear) begin
        fill_hist();
        m_cnt = 0;
        m_ovr = 1'b0;
      end else if (shift_enable) begin
        hist.push_back(serial_in);
        void'(hist.pop_front());
        m_cnt = m_cnt + 1;
        if (m_cnt == N) begin
          m_cnt = 0;
          done = 1'b1;
        end
      end
      if (done) begin
        if (!m_valid || word_ready) begin
          m_word_m = view(1'b1);
          m_word_l = view(1'b0);
          m_valid  = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (xfer) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pout_msb", pout_m, view(1'b1));
      chk("pout_lsb", pout_l, view(1'b0));
      chk("cnt_msb", cnt_m, m_cnt);
      chk("cnt_lsb", cnt_l, m_cnt);
      chk("word_msb", word_m, m_word_m);
      chk("word_lsb", word_l, m_word_l);
      chk("valid_msb", wv_m, m_valid);
      chk("valid_lsb", wv_l, m_valid);
      chk("ovr_msb", ovr_m, m_ovr);
      chk("ovr_lsb", ovr_l, m_ovr);
    end
  end

  task automatic cyc(input logic r, input logic se, input logic si,
                     input logic cl, input logic rdy);
    rst = r; shift_enable = se; serial_in = si; clear = cl; word_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  // Send a byte MSB-first; word_ready = rdy, except rdy_last on the 8th bit.
  task automatic send_msb(input logic [7:0] v, input logic rdy, input logic rdy_last);
    for (int i = 7; i >= 0; i--) cyc(1'b0, 1'b1, v[i], 1'b0, (i == 0) ? rdy_last : rdy);
  endtask

  // Send a byte LSB-first with an idle gap after every odd bit.
  task automatic send_lsb_gaps(input logic [7:0] v, input logic rdy);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, v[i], 1'b0, rdy);
      if (i % 2 == 1 && i != 7) cyc(1'b0, 1'b0, 1'b0, 1'b0, rdy);
    end
  endtask

  initial begin
    fill_hist();
    m_cnt = 0; m_word_m = '0; m_word_l = '0; m_valid = 1'b0; m_ovr = 1'b0;

    // Reset for two cycles, then release with shift_enable low.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_pout", pout_m, 32'h0000_00FF);
    chk("rst_cnt", cnt_m, 32'h0);
    chk("rst_valid", wv_m, 32'h0);
    chk("rst_ovr", ovr_m, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold_pout", pout_l, 32'h0000_00FF);
    chk("hold_word", word_m, 32'h0);

    // Basic word, consumer ready: MSB-first 0x1E.
    send_msb(8'h1E, 1'b1, 1'b1);
    chk("basic_word_msb", word_m, 32'h0000_001E);
    chk("basic_word_lsb", word_l, 32'h0000_0078);
    chk("basic_model", m_word_m, 32'h0000_001E);
    chk("basic_valid", wv_m, 32'h1);
    chk("basic_cnt", cnt_m, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("basic_drop", wv_m, 32'h0);

    // LSB-first 0x1E with idle gaps mid-word.
    send_lsb_gaps(8'h1E, 1'b1);
    chk("gap_word_lsb", word_l, 32'h0000_001E);
    chk("gap_model", m_word_l, 32'h0000_001E);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: second word is dropped, overrun sticks until clear.
    send_msb(8'h1E, 1'b0, 1'b0);
    send_msb(8'hC3, 1'b0, 1'b0);
    chk("bp_valid", wv_m, 32'h1);
    chk("bp_word", word_m, 32'h0000_001E);
    chk("bp_ovr", ovr_m, 32'h1);
    chk("bp_pout", pout_m, 32'h0000_00C3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_consumed", wv_m, 32'h0);
    chk("bp_ovr_sticky", ovr_m, 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_clear_ovr", ovr_m, 32'h0);

    // Back-to-back: ready only in the completion cycle of the second word.
    send_msb(8'h1E, 1'b0, 1'b0);
    send_msb(8'hA5, 1'b0, 1'b1);
    chk("b2b_word", word_m, 32'h0000_00A5);
    chk("b2b_valid", wv_m, 32'h1);
    chk("b2b_ovr", ovr_m, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Abort: five bits, then clear with shift_enable in the same cycle.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort_cnt5", cnt_m, 32'h5);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("abort_cnt", cnt_m, 32'h0);
    chk("abort_pout", pout_m, 32'h0000_00FF);
    chk("abort_valid", wv_m, 32'h0);
    send_msb(8'h5A, 1'b0, 1'b0);
    chk("abort_word", word_m, 32'h0000_005A);

    // Reset mid-word while a word is still pending.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst2_pout", pout_m, 32'h0000_00FF);
    chk("rst2_cnt", cnt_m, 32'h0);
    chk("rst2_word", word_m, 32'h0);
    chk("rst2_valid", wv_m, 32'h0);
    chk("rst2_ovr", ovr_m, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
